alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
Two-requester front end that shares one ArithmeticLogicUnit-style 16-bit ALU (combinational result, flags registered on Clock when WF=1).
- Arbitrates between requesters and drives ALU operands, FunSel and WF.
- Captures result and flags, then returns them with a one-cycle response pulse.
- Sequences a chained 32-bit add as a two-pass operation: ADD on the low halves, then ADC on the high halves.

Parameters:
- NREQ, 2, number of requesters; fixed at 2, exists only for package consistency.

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- ReqValid  in  2  per-requester request valid
- ReqReady  out  2  per-requester accept; one-hot or zero
- ReqFunSel  in  10  5-bit FunSel per requester; requester i uses [5i+4:5i]
- ReqA  in  64  32-bit operand A per requester
- ReqB  in  64  32-bit operand B per requester
- ReqWide  in  2  chained 32-bit add request
- RspValid  out  2  one-hot, one-cycle completion pulse to the owning requester
- RspResult  out  32  result; valid while RspValid is nonzero
- RspFlags  out  4  {Z,C,N,O}; valid while RspValid is nonzero
- AluA  out  16  to ALU A
- AluB  out  16  to ALU B
- AluFunSel  out  5  to ALU FunSel
- AluWF  out  1  to ALU WF
- AluOut  in  16  from ALU ALUOut
- AluFlags  in  4  from ALU FlagsOut, {Z,C,N,O} = bits [3:0]

Behaviour:
- States: IDLE, ISSUE_LO, ISSUE_HI, RESP.
- Reset values: state IDLE, ReqReady 0, RspValid 0, RspResult 0, RspFlags 0, AluA/AluB/AluFunSel 0, AluWF 0, last-grant pointer = 1 (requester 0 wins first).
- IDLE:
  - ReqReady[g] = 1 only for the grant winner g, and only if ReqValid[g]=1.
  - Round robin: if both are valid, grant the one not served last; the pointer updates on accept only.
  - On accept, latch FunSel, A, B, Wide and owner; go to ISSUE_LO.
- Wide is honoured only when FunSel == 5'b10100. Otherwise the request is narrow and Wide is ignored.
- ISSUE_LO (one cycle):
  - AluA=A[15:0], AluB=B[15:0], AluFunSel=latched FunSel (10100 when wide), AluWF=1.
  - At the closing edge, capture AluOut into result[15:0].
  - Next state: ISSUE_HI if wide, else RESP with result[31:16]=0.
- ISSUE_HI (wide only, one cycle):
  - AluA=A[31:16], AluB=B[31:16], AluFunSel=5'b10101 (ADC, consumes the C set by ISSUE_LO), AluWF=1.
  - Capture AluOut into result[31:16]; go to RESP.
- RESP (one cycle):
  - RspValid[owner]=1, RspResult=result.
  - RspFlags: C, N, O come from AluFlags, which the ALU updated at the last ISSUE edge.
  - Z: for narrow ops, AluFlags[3]; for wide ops, (result == 0), because the ALU's Z reflects only the high half.
  - Return to IDLE. There is no back-pressure and the response cannot be stalled.
- AluWF is 0 in IDLE and RESP. AluFunSel/AluA/AluB are 0 in IDLE. ALU flags are never written outside ISSUE states.
- Latency from the accept edge to RspValid high: narrow 2 cycles, wide 3 cycles. Maximum throughput is one accept per 3 (narrow) or 4 (wide) cycles.
- A requester dropping ReqValid before it is accepted is legal; no state changes.
- Operand ports are sampled only at accept. Later changes have no effect.
- Reset asserted in any state: return to IDLE next edge and drop the in-flight op with no response. ALU flags may hold partial state; the sequencer does not restore them.
- RspResult/RspFlags hold their last value outside RESP.

Optional Feature:
- Macro ALU_SEQ_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins when both are valid, and the pointer logic is removed.
- Undefined (default): round robin as above.

Decomposition:
- Package alu_seq_pkg:
  - State enum {IDLE, ISSUE_LO, ISSUE_HI, RESP}.
  - FunSel constants FS_ADD16=5'b10100, FS_ADC16=5'b10101, FS_NOP=5'b00000.
  - Flag index constants FLG_Z=3, FLG_C=2, FLG_N=1, FLG_O=0.
- Sub-module: alu_seq_arb2, a 2-way round-robin or fixed-priority grant with pointer, honouring ALU_SEQ_FIXED_PRIO_EN.

Test Plan:
- Req0 narrow add, FunSel 10100, A=0x00001234, B=0x00000001 -> RspValid=2'b01 two cycles after accept, RspResult=0x00001235, RspFlags=4'b0000.
- Req1 wide add, A=0x0000FFFF, B=0x00000001 -> ISSUE_LO drives FunSel 10100, ISSUE_HI drives 10101; RspResult=0x00010000, Z=0, C=0, RspValid=2'b10 three cycles after accept.
- Req0 wide add, A=0xFFFFFFFF, B=0x00000001 -> RspResult=0x00000000, Z=1, C=1, N=0.
- Both ReqValid held high for 4 transactions -> grants 0,1,0,1; with ALU_SEQ_FIXED_PRIO_EN -> 0,0,0,0.
- Req0 narrow XOR, FunSel 11001, A=0xAAAA, B=0xFFFF, Wide=1 -> Wide ignored, single pass, RspResult=0x00005555, N=0, Z=0.
- Reset asserted during ISSUE_HI -> no RspValid, AluWF=0 next cycle, state IDLE; a pending ReqValid gets ReqReady the following cycle.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU operation sequencer.
//   alu_seq_state_e : sequencer FSM states
//   FS_*            : ALU FunSel encodings used by the sequencer
//   FLG_*           : bit positions inside the {Z,C,N,O} flag nibble
package alu_seq_pkg;

    localparam int unsigned NREQ = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_LO = 2'd1,
        ISSUE_HI = 2'd2,
        RESP     = 2'd3
    } alu_seq_state_e;

    localparam logic [4:0] FS_ADD16 = 5'b10100;
    localparam logic [4:0] FS_ADC16 = 5'b10101;
    localparam logic [4:0] FS_NOP   = 5'b00000;

    localparam int unsigned FLG_Z = 3;
    localparam int unsigned FLG_C = 2;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_O = 0;

endpackage

// File: rtl/alu_seq_arb2.sv
// alu_seq_arb2: two-way grant for the ALU sequencer.
//   Clock    in  : system clock, rising edge
//   Reset    in  : synchronous active-high reset
//   ReqValid in  : per-requester valid
//   Accept   in  : a grant was taken this cycle; advances the pointer
//   Grant    out : one-hot or zero winner, only ever for a valid requester
// Macro ALU_SEQ_FIXED_PRIO_EN selects fixed priority (requester 0 first);
// otherwise round robin with a last-served pointer.
module alu_seq_arb2 (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] ReqValid,
    input  logic       Accept,
    output logic [1:0] Grant
);

`ifdef ALU_SEQ_FIXED_PRIO_EN
    logic unused_fixed;
    assign unused_fixed = ^{Clock, Reset, Accept};

    always_comb begin
        Grant = 2'b00;
        if (ReqValid[0]) begin
            Grant = 2'b01;
        end else if (ReqValid[1]) begin
            Grant = 2'b10;
        end
    end
`else
    // Index of the requester served last; resets to 1 so requester 0 wins first.
    logic last_q;

    always_comb begin
        Grant = 2'b00;
        case (ReqValid)
            2'b01:   Grant = 2'b01;
            2'b10:   Grant = 2'b10;
            2'b11:   Grant = last_q ? 2'b01 : 2'b10;
            default: Grant = 2'b00;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            last_q <= 1'b1;
        end else if (Accept) begin
            last_q <= Grant[1];
        end
    end
`endif

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: two-requester front end sharing one 16-bit ALU.
//   Clock, Reset         : rising-edge clock, synchronous active-high reset
//   ReqValid/ReqReady    : per-requester handshake (ready is one-hot or zero)
//   ReqFunSel/ReqA/ReqB  : per-requester FunSel and 32-bit operands
//   ReqWide              : chained 32-bit add (only honoured with FunSel ADD16)
//   RspValid             : one-cycle one-hot completion pulse to the owner
//   RspResult/RspFlags   : result and {Z,C,N,O}; hold their value outside RESP
//   AluA/AluB/AluFunSel/AluWF : registered drive to the ALU
//   AluOut/AluFlags      : combinational ALU result, registered ALU flags
// Macro ALU_SEQ_FIXED_PRIO_EN (in alu_seq_arb2) selects fixed priority.
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NREQ-1:0]       ReqValid,
    output logic [NREQ-1:0]       ReqReady,
    input  logic [5*NREQ-1:0]     ReqFunSel,
    input  logic [32*NREQ-1:0]    ReqA,
    input  logic [32*NREQ-1:0]    ReqB,
    input  logic [NREQ-1:0]       ReqWide,
    output logic [NREQ-1:0]       RspValid,
    output logic [31:0]           RspResult,
    output logic [3:0]            RspFlags,
    output logic [15:0]           AluA,
    output logic [15:0]           AluB,
    output logic [4:0]            AluFunSel,
    output logic                  AluWF,
    input  logic [15:0]           AluOut,
    input  logic [3:0]            AluFlags
);

    alu_seq_state_e state_q;
    logic           owner_q;
    logic           wide_q;
    logic [15:0]    a_hi_q;
    logic [15:0]    b_hi_q;
    logic [15:0]    res_lo_q;
    logic [3:0]     flags_hold_q;

    logic [1:0]     grant;
    logic           accept;
    logic           gidx;
    logic [4:0]     fs_sel;
    logic [31:0]    a_sel;
    logic [31:0]    b_sel;
    logic           wide_sel;
    logic [3:0]     rsp_flags_now;

    alu_seq_arb2 u_arb (
        .Clock    (Clock),
        .Reset    (Reset),
        .ReqValid (ReqValid),
        .Accept   (accept),
        .Grant    (grant)
    );

    assign ReqReady = (state_q == IDLE) ? grant : 2'b00;
    assign accept   = |ReqReady;
    assign gidx     = grant[1];

    assign fs_sel   = gidx ? ReqFunSel[9:5] : ReqFunSel[4:0];
    assign a_sel    = gidx ? ReqA[63:32]    : ReqA[31:0];
    assign b_sel    = gidx ? ReqB[63:32]    : ReqB[31:0];
    assign wide_sel = (gidx ? ReqWide[1] : ReqWide[0]) && (fs_sel == FS_ADD16);

    // The ALU's Z only covers the last 16-bit pass, so wide ops derive Z
    // from the full 32-bit result (already in RspResult during RESP).
    always_comb begin
        rsp_flags_now = AluFlags;
        if (wide_q) begin
            rsp_flags_now[FLG_Z] = (RspResult == 32'h0);
        end
    end

    assign RspFlags = (state_q == RESP) ? rsp_flags_now : flags_hold_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            wide_q       <= 1'b0;
            a_hi_q       <= 16'h0;
            b_hi_q       <= 16'h0;
            res_lo_q     <= 16'h0;
            flags_hold_q <= 4'h0;
            RspValid     <= 2'b00;
            RspResult    <= 32'h0;
            AluA         <= 16'h0;
            AluB         <= 16'h0;
            AluFunSel    <= FS_NOP;
            AluWF        <= 1'b0;
        end else begin
            RspValid <= 2'b00;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        owner_q   <= gidx;
                        wide_q    <= wide_sel;
                        a_hi_q    <= a_sel[31:16];
                        b_hi_q    <= b_sel[31:16];
                        AluA      <= a_sel[15:0];
                        AluB      <= b_sel[15:0];
                        AluFunSel <= fs_sel;
                        AluWF     <= 1'b1;
                        state_q   <= ISSUE_LO;
                    end
                end
                ISSUE_LO: begin
                    res_lo_q <= AluOut;
                    if (wide_q) begin
                        // High half consumes the carry written by the low pass.
                        AluA      <= a_hi_q;
                        AluB      <= b_hi_q;
                        AluFunSel <= FS_ADC16;
                        AluWF     <= 1'b1;
                        state_q   <= ISSUE_HI;
                    end else begin
                        AluA      <= 16'h0;
                        AluB      <= 16'h0;
                        AluFunSel <= FS_NOP;
                        AluWF     <= 1'b0;
                        RspValid  <= owner_q ? 2'b10 : 2'b01;
                        RspResult <= {16'h0000, AluOut};
                        state_q   <= RESP;
                    end
                end
                ISSUE_HI: begin
                    AluA      <= 16'h0;
                    AluB      <= 16'h0;
                    AluFunSel <= FS_NOP;
                    AluWF     <= 1'b0;
                    RspValid  <= owner_q ? 2'b10 : 2'b01;
                    RspResult <= {AluOut, res_lo_q};
                    state_q   <= RESP;
                end
                RESP: begin
                    flags_hold_q <= rsp_flags_now;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

endmodule
